// File: rtl/freelist_ctrl.sv
// freelist_ctrl: physical-register free list for a 4-wide rename stage.
// Circular FIFO of free preg numbers with head (allocate), tail (release)
// and arch_head (committed allocations) pointers. A flush snaps head back
// to the committed position in one cycle.
// Optional build macro FL_CHECK_EN adds a sticky fl_err consistency flag.
module freelist_ctrl #(
  parameter int PRF_WIDTH = 6,
  parameter int NUM_AREG  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           alloc_req,
  output logic                 alloc_gnt,
  output logic [PRF_WIDTH-1:0] instr0_prd,
  output logic [PRF_WIDTH-1:0] instr1_prd,
  output logic [PRF_WIDTH-1:0] instr2_prd,
  output logic [PRF_WIDTH-1:0] instr3_prd,
  input  logic [3:0]           rel_vld,
  input  logic [PRF_WIDTH-1:0] rel_preg0,
  input  logic [PRF_WIDTH-1:0] rel_preg1,
  input  logic [PRF_WIDTH-1:0] rel_preg2,
  input  logic [PRF_WIDTH-1:0] rel_preg3,
  input  logic [3:0]           cmt_alloc,
  input  logic                 flush,
  output logic [PRF_WIDTH:0]   free_cnt
`ifdef FL_CHECK_EN
  ,
  output logic                 fl_err
`endif
);

  localparam int DEPTH    = 1 << PRF_WIDTH;
  localparam int NUM_FREE = DEPTH - NUM_AREG;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  logic [PRF_WIDTH-1:0] fifo_q [DEPTH];
  logic [PRF_WIDTH-1:0] head_q, head_d;
  logic [PRF_WIDTH-1:0] tail_q, tail_d;
  logic [PRF_WIDTH-1:0] arch_q, arch_d;

  logic [2:0] n_a, n_r, n_c;
  logic [PRF_WIDTH-1:0] rel_arr [4];
  logic [PRF_WIDTH-1:0] wr_idx  [4];
  logic [PRF_WIDTH-1:0] prd     [4];

  assign n_a = popcnt4(alloc_req);
  assign n_r = popcnt4(rel_vld);
  assign n_c = popcnt4(cmt_alloc);

  assign rel_arr[0] = rel_preg0;
  assign rel_arr[1] = rel_preg1;
  assign rel_arr[2] = rel_preg2;
  assign rel_arr[3] = rel_preg3;

  // Occupancy never exceeds NUM_FREE (< DEPTH), so a plain pointer difference is unambiguous.
  assign free_cnt  = {1'b0, tail_q - head_q};
  assign alloc_gnt = ((PRF_WIDTH+1)'(n_a) <= free_cnt) && !flush;

  // Per-slot compaction: a requesting slot takes the entry offset by the number of requesters below it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_slot
    localparam logic [3:0] LOWER = 4'((1 << gi) - 1);
    logic [2:0] rd_rank;
    logic [2:0] wr_rank;
    assign rd_rank    = popcnt4(alloc_req & LOWER);
    assign wr_rank    = popcnt4(rel_vld & LOWER);
    assign prd[gi]    = alloc_req[gi] ? fifo_q[head_q + PRF_WIDTH'(rd_rank)] : '0;
    assign wr_idx[gi] = tail_q + PRF_WIDTH'(wr_rank);
  end

  assign instr0_prd = prd[0];
  assign instr1_prd = prd[1];
  assign instr2_prd = prd[2];
  assign instr3_prd = prd[3];

  // Pointer next-state: flush restores head to the committed point, including this cycle's commits.
  always_comb begin
    arch_d = arch_q + PRF_WIDTH'(n_c);
    tail_d = tail_q + PRF_WIDTH'(n_r);
    if (flush) begin
      head_d = arch_d;
    end else if (alloc_gnt) begin
      head_d = head_q + PRF_WIDTH'(n_a);
    end else begin
      head_d = head_q;
    end
  end

  // Pointer registers; reset leaves the upper half of the register file free.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      arch_q <= '0;
      tail_q <= PRF_WIDTH'(NUM_FREE);
    end else begin
      head_q <= head_d;
      arch_q <= arch_d;
      tail_q <= tail_d;
    end
  end

  // Free-list storage: reset preloads the unmapped pregs, releases append at tail in slot order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        fifo_q[e] <= (e < NUM_FREE) ? PRF_WIDTH'(e + NUM_AREG) : '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (rel_vld[k]) begin
          fifo_q[wr_idx[k]] <= rel_arr[k];
        end
      end
    end
  end

`ifdef FL_CHECK_EN
  logic                 fl_err_q;
  logic [PRF_WIDTH-1:0] arch_gap;
  logic                 chk_over, chk_arch, chk_dup;

  assign arch_gap = head_q - arch_q;

  // Consistency checks: overfill, commits outrunning allocation, release of the preg at the head.
  always_comb begin
    chk_over = ((PRF_WIDTH+2)'(free_cnt) + (PRF_WIDTH+2)'(n_r)) > (PRF_WIDTH+2)'(NUM_FREE);
    chk_arch = PRF_WIDTH'(n_c) > arch_gap;
    chk_dup  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (rel_vld[k] && (rel_arr[k] < PRF_WIDTH'(NUM_AREG)) &&
          (rel_arr[k] == fifo_q[head_q]) && (free_cnt != '0)) begin
        chk_dup = 1'b1;
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_err_q <= 1'b0;
    end else if (chk_over || chk_arch || chk_dup) begin
      fl_err_q <= 1'b1;
    end
  end

  assign fl_err = fl_err_q;
`endif

endmodule
